// File: rtl/l1_msg_responder.sv
// l1_msg_responder: answers L2-to-L1 coherence messages.
// Inbound messages are queued in a small FIFO and served one at a time by a
// four-state FSM (IDLE, DECODE, XFER, RESP) that produces ACK, DATA or ERR.
// Optional feature macro: L1_MSG_STATS_EN adds stat_msgs/stat_err counters.
module l1_msg_responder #(
    parameter int unsigned ADDRESS_SIZE = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned DATA_LAT     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    msg_valid,
    output logic                    msg_ready,
    input  logic [2:0]              msg_code,
    input  logic [ADDRESS_SIZE-1:0] msg_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_code,
    output logic [ADDRESS_SIZE-1:0] rsp_addr,
    output logic                    busy
`ifdef L1_MSG_STATS_EN
    ,
    output logic [15:0]             stat_msgs,
    output logic [15:0]             stat_err
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENT_W = ADDRESS_SIZE + 3;

    localparam logic [2:0] MSG_GETLINE        = 3'd1;
    localparam logic [2:0] MSG_SENDLINE       = 3'd2;
    localparam logic [2:0] MSG_INVALIDATELINE = 3'd3;
    localparam logic [2:0] MSG_EVICTLINE      = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_XFER   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RSP_ACK  = 2'd0,
        RSP_DATA = 2'd1,
        RSP_ERR  = 2'd2
    } rsp_t;

    // FIFO storage and bookkeeping
    logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    // FSM registers (outputs are registered directly)
    state_t                  state_q;
    logic [2:0]              code_q;
    logic [7:0]              lat_cnt_q;
    logic                    rsp_valid_q;
    rsp_t                    rsp_code_q;
    logic [ADDRESS_SIZE-1:0] rsp_addr_q;

    // Ready depends only on registered occupancy, so a same-cycle pop never
    // opens a slot for a push while full.
    assign msg_ready = (count_q < CNT_W'(FIFO_DEPTH));
    assign push      = msg_valid && msg_ready;
    assign pop       = (state_q == ST_IDLE) && (count_q != '0);
    assign head      = fifo_mem_q[rd_ptr_q];

    assign rsp_valid = rsp_valid_q;
    assign rsp_code  = rsp_code_q;
    assign rsp_addr  = rsp_addr_q;
    assign busy      = (count_q != '0) || (state_q != ST_IDLE);

    // Next-state for FIFO pointers and occupancy count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO entry write; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem_q[wr_ptr_q] <= {msg_code, msg_addr};
        end
    end

    // FIFO pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Message-handling FSM: pop, decode, optional line transfer, respond
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            code_q      <= '0;
            lat_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= RSP_ACK;
            rsp_addr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        code_q     <= head[ENT_W-1 -: 3];
                        rsp_addr_q <= head[ADDRESS_SIZE-1:0];
                        state_q    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (code_q)
                        MSG_GETLINE, MSG_SENDLINE: begin
                            lat_cnt_q <= 8'(DATA_LAT - 1);
                            state_q   <= ST_XFER;
                        end
                        MSG_INVALIDATELINE, MSG_EVICTLINE: begin
                            rsp_code_q  <= RSP_ACK;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                        default: begin
                            rsp_code_q  <= RSP_ERR;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                    endcase
                end
                ST_XFER: begin
                    if (lat_cnt_q == 8'd0) begin
                        rsp_code_q  <= RSP_DATA;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 8'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef L1_MSG_STATS_EN
    logic [15:0] stat_msgs_q;
    logic [15:0] stat_err_q;
    logic        err_decode;

    assign err_decode = (state_q == ST_DECODE) &&
                        (code_q != MSG_GETLINE) && (code_q != MSG_SENDLINE) &&
                        (code_q != MSG_INVALIDATELINE) && (code_q != MSG_EVICTLINE);

    assign stat_msgs = stat_msgs_q;
    assign stat_err  = stat_err_q;

    // Saturating counters of accepted messages and ERR responses
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_msgs_q <= '0;
            stat_err_q  <= '0;
        end else begin
            if (push && (stat_msgs_q != '1)) begin
                stat_msgs_q <= stat_msgs_q + 16'd1;
            end
            if (err_decode && (stat_err_q != '1)) begin
                stat_err_q <= stat_err_q + 16'd1;
            end
        end
    end
`endif

endmodule
